// File: rtl/debounce_fsm.sv
// Debouncer for a raw mechanical input: synchronizer, tick prescaler, tick counter, 4-state FSM.
// Define DEBOUNCE_SYNC_EN to include the 2-flop input synchronizer.
module debounce_fsm #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy_in,
    output logic db,
    output logic busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_e;

    logic s_in;

`ifdef DEBOUNCE_SYNC_EN
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= noisy_in;
            s2_q <= s1_q;
        end
    end

    assign s_in = s2_q;
`else
    assign s_in = noisy_in;
`endif

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            db_q, db_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic            rising;
    logic            abort;

    assign tick   = (pre_q == PRE_MAX);
    assign rising = (state_q == WAIT1);
    assign abort  = (s_in != rising);

    // Counters run only inside a WAIT state and read zero on every entry.
    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        cnt_d   = '0;
        unique case (state_q)
            ZERO: begin
                if (s_in) state_d = WAIT1;
            end
            ONE: begin
                if (!s_in) state_d = WAIT0;
            end
            WAIT1, WAIT0: begin
                if (abort) begin
                    state_d = rising ? ZERO : ONE;
                end else if (tick && (cnt_q == CNT_MAX)) begin
                    state_d = rising ? ONE : ZERO;
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    pre_d = pre_q + PW'(1);
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ZERO;
        endcase
        db_d   = (state_d == ONE) || (state_d == WAIT0);
        busy_d = (state_d == WAIT1) || (state_d == WAIT0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ZERO;
            pre_q   <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
        end
    end

    assign db   = db_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with TICK_DIV=4, STABLE_TICKS=3.
// Latency adapts to whether DEBOUNCE_SYNC_EN is defined.
module tb_debounce_fsm;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int N  = TD * ST;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic noisy_in;
    logic db;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;

    debounce_fsm #(
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .noisy_in(noisy_in),
        .db      (db),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic din);
        noisy_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input int j,
                        input logic eb, input logic ed);
        check($sformatf("%s busy j=%0d", tag, j), 32'(busy), 32'(eb));
        check($sformatf("%s db j=%0d", tag, j), 32'(db), 32'(ed));
    endtask

    initial begin
        reset    = 1'b1;
        noisy_in = 1'b0;
        #1;
        chk2("rst_now", 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk2("rst_end", 0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 50; j++) begin
            cyc(1'b0);
            chk2("idle", j, 1'b0, 1'b0);
        end

        // Drop on the very cycle qualification would have completed.
        for (int j = 0; j < LAT + N + 4; j++) begin
            cyc(j < N);
            chk2("term_abort", j,
                 (j >= LAT) && (j < LAT + N), 1'b0);
        end

        for (int j = 0; j < LAT + N + 4; j++) begin
            cyc(1'b1);
            chk2("press", j,
                 (j >= LAT) && (j < LAT + N), j >= LAT + N);
        end

        for (int j = 0; j < LAT + N + 4; j++) begin
            cyc(1'b0);
            chk2("release", j,
                 (j >= LAT) && (j < LAT + N), j < LAT + N);
        end

        for (int j = 0; j < LAT + N + 11; j++) begin
            cyc((j < 5) || (j >= 7));
            chk2("bounce_press", j,
                 ((j >= LAT) && (j < LAT + 5)) ||
                 ((j >= LAT + 7) && (j < LAT + 7 + N)),
                 j >= LAT + 7 + N);
        end

        for (int j = 0; j < LAT + N + 13; j++) begin
            cyc((j < 3) || ((j >= 6) && (j < 9)));
            chk2("bounce_rel", j,
                 ((j >= LAT + 3) && (j < LAT + 6)) ||
                 ((j >= LAT + 9) && (j < LAT + 9 + N)),
                 j < LAT + 9 + N);
        end

        for (int j = 0; j <= 8; j++) begin
            cyc(1'b1);
            chk2("mid_pre", j, j >= LAT, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk2("mid_rst_now", 0, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            cyc(1'b1);
            chk2("mid_rst_hold", j, 1'b0, 1'b0);
        end
        reset = 1'b0;
        for (int j = 0; j < LAT + N + 4; j++) begin
            cyc(1'b1);
            chk2("mid_after", j,
                 (j >= LAT) && (j < LAT + N), j >= LAT + N);
        end

        #2;
        reset = 1'b1;
        #1;
        chk2("one_rst_now", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0);
        chk2("one_rst_after", 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
